// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state encodings,
// default widths and the saturating operand counter helper.
package calc_pkg;

  localparam int OP_W_DEF  = 8;
  localparam int ACC_W_DEF = 12;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_ACCUM = 3'd2,
    ST_TOTAL = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Operand count sticks at its maximum instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Turns a held button level into a single-cycle event on its first high cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic hist_q;

  // Remember last cycle's level; cleared in reset so a level already high
  // at reset release still produces one event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: loads operands, accumulates them with a saturating
// add, produces totals and parks in an error state on decoder conflicts.
module calc_sequencer #(
  parameter int OP_W  = calc_pkg::OP_W_DEF,
  parameter int ACC_W = calc_pkg::ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enterCmd,
  input  logic                    numberCmd,
  input  logic                    totalCmd,
  input  logic                    clearCmd,
  input  logic                    cmdErr,
  input  logic [OP_W-1:0]         numIn,
  output logic [ACC_W-1:0]        display,
  output logic [calc_pkg::CNT_W-1:0] count,
  output logic                    ovf,
  output logic                    errFlag,
  output logic                    totalValid,
  output logic [2:0]              state
);

  import calc_pkg::*;

  // Command levels packed so one edge detector per command can be generated.
  localparam int N_CMD   = 4;
  localparam int IDX_ENT = 0;
  localparam int IDX_NUM = 1;
  localparam int IDX_TOT = 2;
  localparam int IDX_CLR = 3;

  logic [N_CMD-1:0] cmd_lvl;
  logic [N_CMD-1:0] cmd_ev;

  assign cmd_lvl = {clearCmd, totalCmd, numberCmd, enterCmd};

  generate
    for (genvar gi = 0; gi < N_CMD; gi++) begin : g_edge
      rise_detect u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (cmd_lvl[gi]),
        .pulse_o (cmd_ev[gi])
      );
    end
  endgenerate

  logic ent_ev, num_ev, tot_ev, clr_ev;
  assign ent_ev = cmd_ev[IDX_ENT];
  assign num_ev = cmd_ev[IDX_NUM];
  assign tot_ev = cmd_ev[IDX_TOT];
  assign clr_ev = cmd_ev[IDX_CLR];

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [OP_W-1:0]    operand_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   display_q;
  logic               err_flag_q;
  logic               total_valid_q;

  // Result of folding the pending operand into the accumulator; shared by
  // the enter path and the total-from-ENTRY path so both add identically.
  logic [ACC_W:0]     sum_d;
  logic [ACC_W-1:0]   acc_add_d;
  logic               ovf_add_d;
  logic [CNT_W-1:0]   count_inc_d;
  logic [ACC_W-1:0]   num_ext_d;

  assign num_ext_d   = ACC_W'(numIn);
  assign sum_d       = {1'b0, acc_q} + {1'b0, ACC_W'(operand_q)};
  assign acc_add_d   = sum_d[ACC_W] ? '1 : sum_d[ACC_W-1:0];
  assign ovf_add_d   = ovf_q | sum_d[ACC_W];
  assign count_inc_d = sat_inc(count_q);

  // Sequencer FSM with all outputs registered: clear beats cmdErr, which
  // beats number/total/enter (taken in that order).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      operand_q     <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      display_q     <= '0;
      err_flag_q    <= 1'b0;
      total_valid_q <= 1'b0;
    end else begin
      total_valid_q <= 1'b0;
      if (clr_ev) begin
        state_q    <= ST_IDLE;
        acc_q      <= '0;
        operand_q  <= '0;
        count_q    <= '0;
        ovf_q      <= 1'b0;
        display_q  <= '0;
        err_flag_q <= 1'b0;
      end else if (cmdErr) begin
        state_q    <= ST_ERR;
        err_flag_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_ENTRY, ST_ACCUM, ST_TOTAL: begin
            if (num_ev) begin
              if (state_q == ST_TOTAL) begin
                acc_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
              end
              operand_q <= numIn;
              display_q <= num_ext_d;
              state_q   <= ST_ENTRY;
            end else if (tot_ev) begin
              if (state_q == ST_ENTRY) begin
                acc_q         <= acc_add_d;
                ovf_q         <= ovf_add_d;
                count_q       <= count_inc_d;
                display_q     <= acc_add_d;
                total_valid_q <= 1'b1;
                state_q       <= ST_TOTAL;
              end else if (state_q == ST_ACCUM) begin
                display_q     <= acc_q;
                total_valid_q <= 1'b1;
                state_q       <= ST_TOTAL;
              end else if (state_q == ST_IDLE) begin
                display_q     <= '0;
                total_valid_q <= 1'b1;
                state_q       <= ST_TOTAL;
              end
            end else if (ent_ev && (state_q == ST_ENTRY)) begin
              acc_q     <= acc_add_d;
              ovf_q     <= ovf_add_d;
              count_q   <= count_inc_d;
              display_q <= acc_add_d;
              state_q   <= ST_ACCUM;
            end
          end
          ST_ERR: begin
            // Held here until a clear event.
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign display    = display_q;
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign errFlag    = err_flag_q;
  assign totalValid = total_valid_q;
  assign state      = state_q;

endmodule
